// File: rtl/goldschmidt_div_arbiter.sv
// Round-robin front end for a shared, fixed-latency pipelined Goldschmidt
// divider. One operand pair is accepted per cycle at most. A tag pipeline that
// matches the divider latency carries the requester ID and a divide-by-zero
// flag, so each quotient is steered back to the requester that issued it.
// The divider cannot stall, so responses carry no backpressure.
module goldschmidt_div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIV_LATENCY = 14,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic [31:0]            div_quotient,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_quotient,
  output logic                   rsp_dbz,
  output logic [CNT_W-1:0]       inflight_count,
  output logic                   idle
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            dbz;
  } tag_t;

  // Index of the stage whose contents line up with a valid divider output.
  localparam int LAST = DIV_LATENCY;

  logic [31:0]        w_a_arr [NUM_REQ];
  logic [31:0]        w_b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_idx;
  logic               w_accept;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic               w_sel_dbz;
  tag_t               w_last;

  logic [ID_W-1:0]    r_rr;
  logic [31:0]        r_div_a;
  logic [31:0]        r_div_b;
  tag_t               r_tag [LAST+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [31:0]        r_rsp_quotient;
  logic               r_rsp_dbz;
  logic [CNT_W-1:0]   r_inflight;

  // Unpack the flat operand buses into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[32*g +: 32];
    assign w_b_arr[g] = req_b[32*g +: 32];
  end

  // Round-robin scan starting at the pointer; the first valid requester wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_grant    = '0;
    w_grant_id = '0;
    w_accept   = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr) + k) % NUM_REQ);
      if (!w_accept && req_valid[w_idx]) begin
        w_accept       = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_id     = w_idx;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_sel_a   = w_a_arr[w_grant_id];
  assign w_sel_b   = w_b_arr[w_grant_id];
  assign w_sel_dbz = (w_sel_b == 32'd0);
  assign w_last    = r_tag[LAST];

  // Issue: capture the granted operands and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flop state is updated with non-blocking assignments only, so every
    // block sees the pre-edge value of every other register.
    if (!rst_n) begin
      r_div_a <= '0;
      r_div_b <= '0;
      r_rr    <= '0;
    end else if (w_accept) begin
      r_div_a <= w_sel_a;
      // A zero divisor is replaced by 1 so the divider never sees 0; the
      // result is overridden at the response stage anyway.
      r_div_b <= w_sel_dbz ? 32'h0000_0001 : w_sel_b;
      r_rr    <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
    end
  end

  // Tag pipeline: shifts every edge, stage 0 records this cycle's acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this pipeline is reset (unlike a plain data delay line) because a
      // stale vld bit would fire a response for an operation lost to reset.
      for (int s = 0; s <= LAST; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= '{vld: w_accept, id: w_grant_id, dbz: w_accept & w_sel_dbz};
      for (int s = 1; s <= LAST; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Response: steer the divider output back to its originating requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid    <= '0;
      r_rsp_quotient <= '0;
      r_rsp_dbz      <= 1'b0;
    end else begin
      r_rsp_valid <= w_last.vld ? (NUM_REQ'(1) << w_last.id) : '0;
      r_rsp_dbz   <= w_last.vld & w_last.dbz;
      if (w_last.vld) begin
        r_rsp_quotient <= w_last.dbz ? 32'hFFFF_FFFF : div_quotient;
      end
    end
  end

  // In-flight counter: acceptances in, responses out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_last.vld})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign div_a          = r_div_a;
  assign div_b          = r_div_b;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_quotient   = r_rsp_quotient;
  assign rsp_dbz        = r_rsp_dbz;
  assign inflight_count = r_inflight;
  assign idle           = (r_inflight == '0) && (req_valid == '0);

endmodule

// File: doc/goldschmidt_div_arbiter.md
Name: goldschmidt_div_arbiter

Overview:
Shares one fixed-latency pipelined Goldschmidt divider among NUM_REQ requesters. Each cycle a round-robin arbiter accepts at most one operand pair and drives it into the divider. A sideband tag pipeline, matched to the divider latency, carries the requester ID and a divide-by-zero flag alongside the operation, so each quotient is returned to its originator. The divider cannot stall, so responses have no backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ
DIV_LATENCY, 14, clock edges from div_a/div_b changing to div_quotient valid (2 x divider iterations)
CNT_W, 5, width of inflight_count; must hold DIV_LATENCY+1

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and rr pointer
req_a  in  32*NUM_REQ  dividends, requester i at [32i+31:32i]
req_b  in  32*NUM_REQ  divisors, same packing
div_a  out  32  registered dividend to divider
div_b  out  32  registered divisor to divider
div_quotient  in  32  divider result
rsp_valid  out  NUM_REQ  one-hot registered response strobe
rsp_quotient  out  32  registered quotient, meaningful only while rsp_valid != 0
rsp_dbz  out  1  registered; set with rsp_valid when the divisor was 0
inflight_count  out  CNT_W  operations accepted and not yet responded
idle  out  1  high when inflight_count == 0 and req_valid == 0

Behaviour:
- Reset (async assert, sync release): div_a, div_b, rsp_quotient = 0; rsp_valid = 0; rsp_dbz = 0; rr pointer = 0; tag pipeline all invalid; inflight_count = 0. Reset mid-operation discards all in-flight operations. No rsp_valid may fire for operations accepted before reset.
- Arbitration: scan begins at the rr pointer and wraps modulo NUM_REQ. The first i with req_valid[i] = 1 is granted, and req_ready[i] = 1. At most one bit of req_ready is high. req_ready = 0 when req_valid = 0. req_ready is never high for a requester whose req_valid is low.
- Handshake: an operation is accepted on an edge where req_valid[i] and req_ready[i] are both high. Requesters must hold req_a and req_b stable while req_valid is high and unaccepted. On acceptance, the rr pointer moves to (i+1) mod NUM_REQ. With no acceptance, the pointer holds.
- Issue: on acceptance, div_a <= req_a[i]. If req_b[i] == 0, div_b <= 32'h0000_0001 so the divider never sees 0; otherwise div_b <= req_b[i]. With no acceptance, div_a and div_b hold their values and no tag is inserted.
- Tag pipeline: DIV_LATENCY+1 stages of {vld, id[ID_W], dbz}, shifting every edge. Stage 0 loads {accept, i, req_b[i]==0} on every edge.
- Response: the edge after the divider output becomes valid (acceptance edge + DIV_LATENCY + 1) updates the outputs:
  - rsp_valid <= one-hot(id) if the last stage is valid, else 0.
  - rsp_quotient <= 32'hFFFF_FFFF if dbz, else div_quotient. rsp_quotient holds its value when there is no response.
  - rsp_dbz <= dbz & vld.
- Throughput: one acceptance per cycle sustained. The response stream preserves acceptance order exactly, with gaps preserved.
- inflight_count: +1 on acceptance, -1 on a response edge, unchanged when both occur on the same edge. Never exceeds DIV_LATENCY+1.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,… Any continuously valid requester is granted within NUM_REQ cycles.
- Requesters must accept a response whenever one arrives; there is no response backpressure.

Test Plan:
- Reset, then a single request: req_valid = 4'b0100, a = 32'h0006_0000, b = 32'h0002_0000, divider stub = DIV_LATENCY delay line returning {a[15:0], b[15:0]} -> req_ready = 4'b0100 in the same cycle; rsp_valid = 4'b0100 exactly 15 edges after acceptance; rsp_quotient = stub value; inflight_count 1 -> 0.
- All four valid for 12 cycles with distinct operands -> grants 0,1,2,3 repeating; 12 responses on consecutive cycles, each one-hot to its originator and in acceptance order; inflight_count peaks at 12.
- Requester 1 valid with b = 0 -> div_b = 1 is driven; response has rsp_quotient = 32'hFFFF_FFFF and rsp_dbz = 1 for exactly one cycle.
- Accept on cycle 0, idle for cycles 1-2, accept on cycle 3 -> responses 15 and 18 edges after start, with the two-cycle gap preserved; idle = 1 only after the second response.
- Fill the pipeline with 10 operations, assert rst_n = 0 asynchronously mid-cycle, release -> rsp_valid and inflight_count go to 0 immediately; no responses during the next 20 cycles.
- Requesters 0 and 3 held valid, rr pointer at 1 -> 3 is granted first, then 0, then alternation 3,0,3,…
